// File: rtl/obi_wb_pkg.sv
// obi_wb_pkg: shared types and helpers for the OBI-to-Wishbone bridge.
//   state_e   : bridge FSM states (IDLE, BUSY, ABORT)
//   cnt_width : width needed to hold an outstanding count of 0..max_out
package obi_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/obi_wb_resp_reg.sv
// obi_wb_resp_reg: one-stage register on the Wishbone response path.
// Ports:
//   clk_core, rst_core       : clock, synchronous active-high reset
//   wb_ack, wb_err, wb_dat   : raw Wishbone response inputs
//   resp_ack, resp_err,
//   resp_dat                 : responses delayed by one cycle
module obi_wb_resp_reg #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_core,
    input  logic                  rst_core,
    input  logic                  wb_ack,
    input  logic                  wb_err,
    input  logic [DATA_WIDTH-1:0] wb_dat,
    output logic                  resp_ack,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_dat
);

    // Capture every cycle; the bridge decides whether a response is meaningful.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            resp_ack <= 1'b0;
            resp_err <= 1'b0;
            resp_dat <= '0;
        end else begin
            resp_ack <= wb_ack;
            resp_err <= wb_err;
            resp_dat <= wb_dat;
        end
    end

endmodule

// File: rtl/obi_wb_bridge.sv
// obi_wb_bridge: OBI slave to pipelined Wishbone master bridge with an
// outstanding-transaction limit and an ack watchdog that aborts the cycle
// and answers every outstanding request with an error.
// Configuration macro: OBI_WB_RESP_REG_EN -- registers wb_ack_i/wb_err_i/
// wb_dat_i one stage before use (responses appear one cycle after the ack).
// Ports:
//   clk_core, rst_core                     : clock, synchronous active-high reset
//   req_i/gnt_o/addr_i/we_i/be_i/wdata_i   : OBI request channel
//   rvalid_o/rdata_o/err_o                 : OBI response channel
//   wb_cyc_o/wb_stb_o/wb_we_o/wb_sel_o/
//   wb_addr_o/wb_dat_o                     : Wishbone request
//   wb_dat_i/wb_ack_i/wb_err_i/wb_stall_i  : Wishbone response / flow control
//   busy_o                                 : transactions in flight or not idle
module obi_wb_bridge
    import obi_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_stall_i,
    output logic                    busy_o
);

    localparam int unsigned CNT_W = cnt_width(MAX_OUTSTANDING);
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic                  resp_ack;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_dat;

    logic in_abort;
    logic has_out;
    logic accept;
    logic resp_fire;
    logic drain;
    logic wd_expire;

    // Response source: registered or straight from the bus.
`ifdef OBI_WB_RESP_REG_EN
    obi_wb_resp_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_resp_reg (
        .clk_core (clk_core),
        .rst_core (rst_core),
        .wb_ack   (wb_ack_i),
        .wb_err   (wb_err_i),
        .wb_dat   (wb_dat_i),
        .resp_ack (resp_ack),
        .resp_err (resp_err),
        .resp_dat (resp_dat)
    );
`else
    assign resp_ack = wb_ack_i;
    assign resp_err = wb_err_i;
    assign resp_dat = wb_dat_i;
`endif

    assign in_abort = (state_q == ST_ABORT);
    assign has_out  = (count_q != '0);

    // Request side: strobe while there is room, grant when the slave is not stalling.
    assign wb_stb_o  = ~rst_core & req_i & ~in_abort & (count_q < CNT_W'(MAX_OUTSTANDING));
    assign gnt_o     = wb_stb_o & ~wb_stall_i;
    assign accept    = gnt_o;
    assign wb_cyc_o  = ~rst_core & ~in_abort & (wb_stb_o | has_out);
    assign wb_we_o   = we_i;
    assign wb_sel_o  = be_i;
    assign wb_addr_o = addr_i;
    assign wb_dat_o  = wdata_i;

    // Response side: real responses only count with something outstanding;
    // in ABORT each cycle retires one outstanding transaction as an error.
    assign resp_fire = ~rst_core & ~in_abort & has_out & (resp_ack | resp_err);
    assign drain     = ~rst_core & in_abort & has_out;
    assign rvalid_o  = resp_fire | drain;
    assign err_o     = drain | (resp_fire & resp_err);
    assign rdata_o   = resp_fire ? resp_dat : '0;
    assign busy_o    = ~rst_core & (has_out | (state_q != ST_IDLE));

    // Ack watchdog: consecutive cycles waiting with nothing answered.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            logic [WD_W-1:0] wd_q;
            logic            wd_run;

            assign wd_run    = ~in_abort & has_out & ~resp_fire;
            assign wd_expire = wd_run & (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

            always_ff @(posedge clk_core) begin
                if (rst_core) begin
                    wd_q <= '0;
                end else if (wd_run & ~wd_expire) begin
                    wd_q <= wd_q + WD_W'(1);
                end else begin
                    wd_q <= '0;
                end
            end
        end else begin : g_no_wd
            assign wd_expire = 1'b0;
        end
    endgenerate

    // State and outstanding-count register.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state and count update.
    always_comb begin
        state_d = state_q;
        count_d = count_q;

        if (accept & ~resp_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (~accept & (resp_fire | drain)) begin
            count_d = count_q - CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (wd_expire) begin
                    state_d = ST_ABORT;
                end else if (count_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                if (count_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/obi_wb_bridge.md
OBI_WB_BRIDGE -- requirements
Module: obi_wb_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width on both sides.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; a multiple of 8; byte-enable width is DATA_WIDTH/8.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, maximum accepted-but-unanswered transactions; range 1..15.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, ack watchdog limit; 0 disables the watchdog.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk_core input 1 (all state on rising edge); rst_core input 1 (synchronous, active-high).
REQ-006 SHALL have OBI request ports: req_i in 1; gnt_o out 1; addr_i in ADDR_WIDTH; we_i in 1; be_i in DATA_WIDTH/8; wdata_i in DATA_WIDTH.
REQ-007 SHALL have OBI response ports: rvalid_o out 1; rdata_o out DATA_WIDTH; err_o out 1.
REQ-008 SHALL have pipelined Wishbone master ports: wb_cyc_o out 1; wb_stb_o out 1; wb_we_o out 1; wb_sel_o out DATA_WIDTH/8; wb_addr_o out ADDR_WIDTH; wb_dat_o out DATA_WIDTH; wb_dat_i in DATA_WIDTH; wb_ack_i in 1; wb_err_i in 1; wb_stall_i in 1.
REQ-009 SHALL have status output busy_o out 1, high whenever the outstanding count is non-zero or state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE (no cycle), BUSY (wb_cyc_o=1), ABORT (watchdog recovery).
REQ-011 SHALL drive wb_stb_o = req_i & (count < MAX_OUTSTANDING) & state!=ABORT; address, we, sel and data pass combinationally from OBI inputs.
REQ-012 SHALL drive gnt_o = wb_stb_o & ~wb_stall_i; a transfer is accepted exactly in cycles where gnt_o=1.
REQ-013 SHALL hold wb_cyc_o high whenever wb_stb_o=1 or count>0, outside ABORT.
REQ-014 SHALL increment count on acceptance, decrement on a response (ack or err); simultaneous accept and response leaves count unchanged.
REQ-015 SHALL emit rvalid_o=1 for each wb_ack_i or wb_err_i, with rdata_o=wb_dat_i and err_o=wb_err_i; responses are in order, one per cycle.
REQ-016 SHALL ignore wb_ack_i/wb_err_i when count=0 (and the response register holds none) -- no rvalid_o, no underflow.
REQ-017 SHALL transition IDLE->BUSY on first acceptance and BUSY->IDLE when count reaches 0 with no new acceptance that cycle.
REQ-018 SHALL, with TIMEOUT_CYCLES>0, count cycles with count>0 and no response, clear on any response, and enter ABORT on reaching TIMEOUT_CYCLES.
REQ-019 SHALL, in ABORT, drive wb_cyc_o=0, wb_stb_o=0, gnt_o=0, ignore late acks, emit one rvalid_o with err_o=1 and rdata_o=0 per cycle until count=0, then return to IDLE.
REQ-020 SHALL keep rdata_o=0 whenever rvalid_o=0.

Reset
REQ-021 SHALL, on rst_core at a clock edge, clear count, watchdog and response register, set state IDLE; all registered outputs 0 next cycle; in-flight transactions are dropped with no response.
REQ-022 SHALL, while rst_core=1, hold gnt_o, wb_cyc_o, wb_stb_o, rvalid_o, busy_o at 0.

Configuration
REQ-023 SHALL provide macro OBI_WB_RESP_REG_EN: when defined, wb_ack_i/wb_err_i/wb_dat_i are registered one stage before use (rvalid_o 1 cycle after ack, count decrements on registered response); when undefined, response path is combinational (rvalid_o same cycle as ack).

Structure
REQ-024 SHALL place the FSM state enum and the count-width function (clog2 of MAX_OUTSTANDING+1) in package obi_wb_pkg.
REQ-025 SHALL contain the response register stage in sub-module obi_wb_resp_reg, instantiated only under OBI_WB_RESP_REG_EN.

Verification
REQ-026 Single read: req_i=1, addr 0x100, stall 0, ack next cycle with 0xDEADBEEF -> gnt_o same cycle, rvalid_o with 0xDEADBEEF (cycle +1, +2 with macro), state back IDLE.
REQ-027 Back-to-back: 3 reads, MAX_OUTSTANDING=2, ack delayed 3 cycles -> gnt_o low for third until first ack; 3 in-order responses.
REQ-028 Stall: wb_stall_i=1 for 4 cycles with req_i=1 -> gnt_o=0, wb_stb_o=1, addr stable; accept on stall release.
REQ-029 Timeout: TIMEOUT_CYCLES=8, 2 outstanding, no ack -> ABORT after 8 cycles, cyc drops, two err_o=1 responses, IDLE; late ack ignored.
REQ-030 Reset mid-operation: rst_core with 2 outstanding -> next cycle count 0, busy_o=0, no rvalid_o.
REQ-031 Error/simultaneity: wb_err_i on write while new request accepted -> err_o=1 response, count unchanged.
